// File: rtl/sig_product_resolver_pkg.sv
// Shared widths, chunk-count helper and FSM encoding for the significand product resolver.
package sig_product_resolver_pkg;

    localparam int unsigned SIG_WIDTH  = 23;
    localparam int unsigned W          = 2 * SIG_WIDTH + 4;
    localparam int unsigned PROD_WIDTH = 2 * SIG_WIDTH + 2;

    function automatic int unsigned num_chunks(input int unsigned width,
                                               input int unsigned chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/sig_product_resolver_chunk_adder.sv
// CHUNK_WIDTH-bit ripple adder with carry in/out, time-multiplexed by the resolver FSM.
module sig_product_resolver_chunk_adder #(
    parameter int unsigned CHUNK_WIDTH = 13
) (
    input  logic [CHUNK_WIDTH-1:0] a,
    input  logic [CHUNK_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [CHUNK_WIDTH-1:0] sum,
    output logic                   cout
);

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < int'(CHUNK_WIDTH); i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/sig_product_resolver.sv
// Multi-cycle carry-propagate resolver for compressor sum/carry vectors.
// Optional sticky accumulation is enabled by defining PROD_STICKY_EN.
module sig_product_resolver
    import sig_product_resolver_pkg::*;
#(
    parameter int unsigned CHUNK_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          sum_in,
    input  logic [W-1:0]          carry_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PROD_WIDTH-1:0] product,
    output logic                  prod_msb,
    output logic                  out_err,
    output logic                  sticky
);

    localparam int unsigned NUM_CHUNKS = num_chunks(W, CHUNK_WIDTH);
    localparam int unsigned KW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int unsigned IW         = $clog2(W);
    localparam logic [KW-1:0] LAST_K   = KW'(NUM_CHUNKS - 1);

    state_e                 state_q;
    logic [KW-1:0]          k_q;
    logic                   carry_q;
    logic [W-1:0]           a_q, b_q, r_q, r_d;
    logic [CHUNK_WIDTH-1:0] a_chunk, b_chunk, chunk_sum;
    logic                   chunk_cout;

    // The carry vector's top bit shifts out of the modular word.
    logic unused_carry_msb;
    assign unused_carry_msb = carry_in[W-1];

`ifdef PROD_STICKY_EN
    logic sticky_q, sticky_d;
    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

    sig_product_resolver_chunk_adder #(
        .CHUNK_WIDTH(CHUNK_WIDTH)
    ) u_chunk_adder (
        .a   (a_chunk),
        .b   (b_chunk),
        .cin (carry_q),
        .sum (chunk_sum),
        .cout(chunk_cout)
    );

    // Bits past W-1 in the last chunk read as zero and are never written back.
    always_comb begin
        int unsigned pos;
        a_chunk = '0;
        b_chunk = '0;
        r_d     = r_q;
`ifdef PROD_STICKY_EN
        sticky_d = sticky_q;
`endif
        for (int i = 0; i < int'(CHUNK_WIDTH); i++) begin
            pos = int'(k_q) * CHUNK_WIDTH + i;
            if (pos < W) begin
                a_chunk[i]      = a_q[IW'(pos)];
                b_chunk[i]      = b_q[IW'(pos)];
                r_d[IW'(pos)]   = chunk_sum[i];
`ifdef PROD_STICKY_EN
                if (pos < SIG_WIDTH) sticky_d = sticky_d | chunk_sum[i];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            prod_msb  <= 1'b0;
            out_err   <= 1'b0;
            k_q       <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
`ifdef PROD_STICKY_EN
            sticky_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= sum_in;
                        b_q      <= {carry_in[W-2:0], 1'b0};
                        k_q      <= '0;
                        carry_q  <= 1'b0;
                        in_ready <= 1'b0;
                        state_q  <= StAdd;
`ifdef PROD_STICKY_EN
                        sticky_q <= 1'b0;
`endif
                    end
                end
                StAdd: begin
                    r_q     <= r_d;
                    carry_q <= chunk_cout;
                    k_q     <= k_q + 1'b1;
`ifdef PROD_STICKY_EN
                    sticky_q <= sticky_d;
`endif
                    if (k_q == LAST_K) begin
                        state_q   <= StDone;
                        out_valid <= 1'b1;
                        product   <= r_d[PROD_WIDTH-1:0];
                        prod_msb  <= r_d[PROD_WIDTH-1];
                        out_err   <= |r_d[W-1:W-2];
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sig_product_resolver.sv
// Directed self-checking bench for sig_product_resolver (honours PROD_STICKY_EN if defined).
module tb_sig_product_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [49:0] sum_in;
    logic [49:0] carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] product;
    logic        prod_msb;
    logic        out_err;
    logic        sticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sig_product_resolver dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum_in   (sum_in),
        .carry_in (carry_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .prod_msb (prod_msb),
        .out_err  (out_err),
        .sticky   (sticky)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_sticky(input logic s);
`ifdef PROD_STICKY_EN
        return s;
`else
        return 1'b0 & s;
`endif
    endfunction

    task automatic wait_valid(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd4);
    endtask

    task automatic check_result(input string tag, input logic [47:0] p, input logic e,
                                input logic s);
        check({tag, " product"}, 64'(product), 64'(p));
        check({tag, " prod_msb"}, 64'(prod_msb), 64'(p[47]));
        check({tag, " out_err"}, 64'(out_err), 64'(e));
        check({tag, " sticky"}, 64'(sticky), 64'(exp_sticky(s)));
    endtask

    task automatic do_op(input string tag, input logic [49:0] s, input logic [49:0] c,
                         input logic [47:0] p, input logic e, input logic st);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        sum_in   = s;
        carry_in = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        sum_in   = '1;
        carry_in = '1;
        wait_valid(tag);
        check_result(tag, p, e, st);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " idle out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " idle in_ready"}, 64'(in_ready), 64'd1);
    endtask

    logic [49:0] full_c;
    logic [49:0] full_s;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        sum_in    = 50'h1234;
        carry_in  = 50'h5678;
        tick();
        tick();
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check_result("reset", 48'h0, 1'b0, 1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();

        do_op("zero", 50'h0, 50'h0, 48'h0, 1'b0, 1'b0);

        // Split 24'hFFFFFF squared into a redundant pair.
        full_c = 50'h0_1234_5678_9ABC;
        full_s = 50'h0_FFFF_FE00_0001 - {full_c[48:0], 1'b0};
        do_op("full", full_s, full_c, 48'hFFFF_FE00_0001, 1'b0, 1'b1);

        do_op("ripple", 50'h0_7FFF_FFFF_FFFE, 50'h1, 48'h8000_0000_0000, 1'b0, 1'b0);
        do_op("err", 50'h1_0000_0000_0000, 50'h0, 48'h0, 1'b1, 1'b0);
        do_op("wrap", 50'h3_FFFF_FFFF_FFFF, 50'h2_0000_0000_0001, 48'h1, 1'b0, 1'b1);

        // Backpressure: hold DONE with a competing in_valid.
        sum_in   = full_s;
        carry_in = full_c;
        in_valid = 1'b1;
        tick();
        sum_in   = 50'h0_7FFF_FFFF_FFFE;
        carry_in = 50'h1;
        wait_valid("bp");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp in_ready", 64'(in_ready), 64'd0);
            check("bp product", 64'(product), 64'h0000_FFFF_FE00_0001);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release out_valid", 64'(out_valid), 64'd0);
        check("bp release in_ready", 64'(in_ready), 64'd1);
        tick();
        check("bp reaccept in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_valid("bp second");
        check_result("bp second", 48'h8000_0000_0000, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset while chunk 2 is being resolved.
        sum_in   = full_s;
        carry_in = full_c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst mid in_ready", 64'(in_ready), 64'd1);
        check("rst mid out_valid", 64'(out_valid), 64'd0);
        check("rst mid product", 64'(product), 64'd0);
        do_op("after rst", full_s, full_c, 48'hFFFF_FE00_0001, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
